// File: rtl/rf_bypass_if.sv
// Operand-fetch bus between the decode side and the rf_bypass register file:
// read/write selects, write data and enable, and the two read results.
interface rf_bypass_if #(
  parameter int WIDTH = 16
);
  logic [2:0]       read1RegSel;
  logic [2:0]       read2RegSel;
  logic [2:0]       writeRegSel;
  logic [WIDTH-1:0] writeData;
  logic             write;
  logic [WIDTH-1:0] read1Data;
  logic [WIDTH-1:0] read2Data;
  logic             err;

  modport master (
    output read1RegSel,
    output read2RegSel,
    output writeRegSel,
    output writeData,
    output write,
    input  read1Data,
    input  read2Data,
    input  err
  );

  modport slave (
    input  read1RegSel,
    input  read2RegSel,
    input  writeRegSel,
    input  writeData,
    input  write,
    output read1Data,
    output read2Data,
    output err
  );
endinterface

// File: rtl/rf_bypass.sv
// Eight-entry register file, two combinational read ports with write-to-read
// bypass, one clocked write port, and a write-during-reset diagnostic flag.
module rf_bypass #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  rf_bypass_if.slave   bus
);

  logic [WIDTH-1:0] regs_r [8];
  logic             err_r;
  logic [WIDTH-1:0] read1_s;
  logic [WIDTH-1:0] read2_s;
  logic             bypass1_s;
  logic             bypass2_s;

  // Register storage: async clear on rst, otherwise one write per rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
    end else if (bus.write) begin
      regs_r[bus.writeRegSel] <= bus.writeData;
    end
  end

  // Diagnostic flag; rst is sampled here on purpose, since an async clear
  // would hide exactly the write-during-reset condition being reported.
  always_ff @(posedge clk) begin
    err_r <= rst & bus.write;
  end

  // Bypass match detection, disabled while reset is asserted.
  always_comb begin
    bypass1_s = 1'b0;
    bypass2_s = 1'b0;
    if (!rst && bus.write) begin
      bypass1_s = (bus.read1RegSel == bus.writeRegSel);
      bypass2_s = (bus.read2RegSel == bus.writeRegSel);
    end else begin
      bypass1_s = 1'b0;
      bypass2_s = 1'b0;
    end
  end

  // Read port 1 mux: reset forces zero, bypass beats stored contents.
  always_comb begin
    read1_s = {WIDTH{1'b0}};
    if (rst) begin
      read1_s = {WIDTH{1'b0}};
    end else if (bypass1_s) begin
      read1_s = bus.writeData;
    end else begin
      read1_s = regs_r[bus.read1RegSel];
    end
  end

  // Read port 2 mux, same priority as port 1.
  always_comb begin
    read2_s = {WIDTH{1'b0}};
    if (rst) begin
      read2_s = {WIDTH{1'b0}};
    end else if (bypass2_s) begin
      read2_s = bus.writeData;
    end else begin
      read2_s = regs_r[bus.read2RegSel];
    end
  end

  assign bus.read1Data = read1_s;
  assign bus.read2Data = read2_s;
  assign bus.err       = err_r;

endmodule
